hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised, stateful successor to the combinational forwarding/stall unit, sitting at decode/issue.
//  Tracks in-flight destination tags in an internal FWD_DEPTH-stage shadow pipeline.
//  Per source operand, emits a one-hot forward select (youngest producer wins) and an issue stall.
//  Handles multi-cycle load latency, early-use operands (address calc, branch) and pipeline flush.
// PARAMETERS
//  REG_BITS   4   register-index width; index 0 is hardwired zero and never forwards or stalls
//  FWD_DEPTH  3   tracked stages after issue (stage 1 = EX ... stage FWD_DEPTH = last forwarding point)
//  LOAD_LAT   1   extra stages beyond an ALU op before load data is forwardable; FWD_DEPTH >= LOAD_LAT+2
//  STAT_W     16  width of statistics counters (optional feature only)
// PORTS
//  clk         in   1          clock
//  rst         in   1          synchronous active-high reset
//  iss_valid   in   1          instruction present at issue
//  rs_a        in   REG_BITS   source A index
//  rs_b        in   REG_BITS   source B index
//  use_a       in   1          A is read
//  use_b       in   1          B is read (deasserted for immediate form)
//  early_a     in   1          A consumed one stage early (address calc, not bypassed)
//  early_b     in   1          B consumed one stage early (branch compare, load address)
//  rd          in   REG_BITS   destination of issuing instruction
//  rd_we       in   1          issuing instruction writes rd
//  is_load     in   1          issuing instruction is a load
//  flush       in   1          kill all in-flight entries (branch redirect)
//  fwd_a       out  FWD_DEPTH  one-hot forward select for A; bit k-1 = stage k; all zero = register file
//  fwd_b       out  FWD_DEPTH  same for B
//  stall       out  1          hold issue this cycle
//  stall_cnt   out  STAT_W     cycles with stall=1 (HAZ_STATS_EN only)
//  fwd_cnt     out  STAT_W     accepted issues with any forward (HAZ_STATS_EN only)
// BEHAVIOUR
//  - Entry per stage: {v, rd, ld}. Each cycle stage k+1 <= stage k; the stage FWD_DEPTH entry retires.
//  - Stage 1 loads {iss_valid & rd_we & |rd & ~stall, rd, is_load}; on stall a bubble (v=0) enters.
//  - Match(op,k): use_op & |rs_op & v[k] & rd[k]==rs_op. Youngest (smallest k) match is the producer.
//  - Ready stage R = 1 + (ld ? LOAD_LAT : 0) + (early_op ? 1 : 0); producer at stage k is ready iff k >= R.
//  - Ready producer: fwd_op one-hot at k. Not ready: fwd_op = 0 and stall contributes.
//  - No match: fwd_op = 0 and no stall. An older match never overrides a younger one.
//  - stall = iss_valid & (notready_a | notready_b); outputs are combinational from stage regs + inputs.
//  - iss_valid=0: stall=0, fwd outputs still valid for observation, stage 1 gets a bubble.
//  - Load-use (LOAD_LAT=1, non-early): 1 stall cycle; consumer then forwards from stage 2.
//  - Early ALU-use: 1 stall cycle, then forward from stage 2.
//  - flush: all v cleared on next edge; stage 1 also gets a bubble even if iss_valid. flush beats issue.
//  - rst: all v=0, counters=0; hence after reset stall=0, fwd_a=fwd_b=0.
//  - rst and flush together: rst behaviour. Reset mid-stall drops the stall next cycle.
//  - Both operands may select the same stage; A and B are fully independent.
// CONFIGURATION
//  HAZ_STATS_EN defined: stall_cnt and fwd_cnt increment per event, saturating at all-ones,
//   cleared by rst only (flush does not clear).
//  HAZ_STATS_EN undefined: no counters; stall_cnt and fwd_cnt tied to 0; other behaviour identical.
// TESTING (defaults)
//  1 rst high 2 cycles -> stall=0, fwd_a=fwd_b=000, counters=0.
//  2 issue rd=3 ALU; next issue rs_a=3 use_a -> fwd_a=001, stall=0; next cycle rs_a=3 -> fwd_a=010.
//  3 issue load rd=5; next rs_b=5 use_b -> stall=1 one cycle, then fwd_b=010, stall=0.
//  4 rd=7 ALU, rd=7 ALU back-to-back; consumer rs_a=7 -> fwd_a=001 (youngest), not 010.
//  5 rs_a=0 after rd=0 or use_b=0 with rs_b match -> fwd=000, stall=0.
//  6 load rd=5, load-use stall, flush next cycle -> stall=0, fwd=000; HAZ_STATS_EN: stall_cnt=1.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Decode/issue hazard scoreboard: shadow pipeline of in-flight destination tags driving
// per-operand one-hot forward selects and an issue stall. Optional counters under HAZ_STATS_EN.
module hazard_scoreboard #(
  parameter int REG_BITS  = 4,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1,
  parameter int STAT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_valid,
  input  logic [REG_BITS-1:0]  rs_a,
  input  logic [REG_BITS-1:0]  rs_b,
  input  logic                 use_a,
  input  logic                 use_b,
  input  logic                 early_a,
  input  logic                 early_b,
  input  logic [REG_BITS-1:0]  rd,
  input  logic                 rd_we,
  input  logic                 is_load,
  input  logic                 flush,
  output logic [FWD_DEPTH-1:0] fwd_a,
  output logic [FWD_DEPTH-1:0] fwd_b,
  output logic                 stall,
  output logic [STAT_W-1:0]    stall_cnt,
  output logic [STAT_W-1:0]    fwd_cnt
);

  logic [FWD_DEPTH:1]               stgV;
  logic [FWD_DEPTH:1]               stgLd;
  logic [FWD_DEPTH:1][REG_BITS-1:0] stgRd;
  logic                             notReadyA;
  logic                             notReadyB;
  logic                             issueWrite;

  // Scans youngest-first; returns {notReady, oneHotSelect}.
  function automatic logic [FWD_DEPTH:0] resolveOp(
    input logic                             opUse,
    input logic [REG_BITS-1:0]              rs,
    input logic                             early,
    input logic [FWD_DEPTH:1]               v,
    input logic [FWD_DEPTH:1][REG_BITS-1:0] rdTag,
    input logic [FWD_DEPTH:1]               ld
  );
    logic [FWD_DEPTH-1:0] sel;
    logic                 nr;
    logic                 found;
    int                   readyStg;
    sel      = '0;
    nr       = 1'b0;
    found    = 1'b0;
    readyStg = 0;
    for (int k = 1; k <= FWD_DEPTH; k++) begin
      if (!found && opUse && (|rs) && v[k] && (rdTag[k] == rs)) begin
        found    = 1'b1;
        readyStg = 1 + (ld[k] ? LOAD_LAT : 0) + (early ? 1 : 0);
        if (k >= readyStg) sel[k-1] = 1'b1;
        else               nr       = 1'b1;
      end
    end
    return {nr, sel};
  endfunction

  always_comb begin
    {notReadyA, fwd_a} = resolveOp(use_a, rs_a, early_a, stgV, stgRd, stgLd);
    {notReadyB, fwd_b} = resolveOp(use_b, rs_b, early_b, stgV, stgRd, stgLd);
    stall              = iss_valid & (notReadyA | notReadyB);
    issueWrite         = iss_valid & rd_we & (|rd) & ~stall & ~flush;
  end

  // Issue -> stage 1 -> ... -> stage FWD_DEPTH (retire)
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      stgV <= '0;
    end else begin
      stgV[1] <= issueWrite;
      for (int k = 2; k <= FWD_DEPTH; k++) stgV[k] <= stgV[k-1];
    end
  end

  always_ff @(posedge clk) begin
    stgRd[1] <= rd;
    stgLd[1] <= is_load;
    for (int k = 2; k <= FWD_DEPTH; k++) begin
      stgRd[k] <= stgRd[k-1];
      stgLd[k] <= stgLd[k-1];
    end
  end

`ifdef HAZ_STATS_EN
  logic [STAT_W-1:0] stallCntR;
  logic [STAT_W-1:0] fwdCntR;

  function automatic logic [STAT_W-1:0] satInc(input logic [STAT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCntR <= '0;
      fwdCntR   <= '0;
    end else begin
      if (stall) stallCntR <= satInc(stallCntR);
      if (iss_valid && !stall && !flush && ((|fwd_a) || (|fwd_b)))
        fwdCntR <= satInc(fwdCntR);
    end
  end

  assign stall_cnt = stallCntR;
  assign fwd_cnt   = fwdCntR;
`else
  assign stall_cnt = '0;
  assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic against an
// issue-history model (producer stage = cycles elapsed since its issue).
module tb_hazard_scoreboard;
  localparam int RB = 4;
  localparam int D  = 3;
  localparam int LL = 1;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst, issValid, useA, useB, earlyA, earlyB, rdWe, isLoad, flush;
  logic [RB-1:0] rsA, rsB, rd;
  logic [D-1:0]  fwdA, fwdB;
  logic          stall;
  logic [SW-1:0] stallCnt, fwdCnt;

  hazard_scoreboard #(.REG_BITS(RB), .FWD_DEPTH(D), .LOAD_LAT(LL), .STAT_W(SW)) dut (
    .clk(clk), .rst(rst), .iss_valid(issValid), .rs_a(rsA), .rs_b(rsB),
    .use_a(useA), .use_b(useB), .early_a(earlyA), .early_b(earlyB),
    .rd(rd), .rd_we(rdWe), .is_load(isLoad), .flush(flush),
    .fwd_a(fwdA), .fwd_b(fwdB), .stall(stall), .stall_cnt(stallCnt), .fwd_cnt(fwdCnt)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int rd; bit ld;} ent_t;
  ent_t          hist[$];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  logic [D-1:0]  expFwdA, expFwdB;
  logic          expStall;
  logic [SW-1:0] mStallCnt = '0;
  logic [SW-1:0] mFwdCnt = '0;
  logic [SW-1:0] statOne;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Youngest issued entry naming rs decides; its age in cycles is its stage.
  function automatic void evalOp(input bit u, input int rs, input bit early,
                                 output logic [D-1:0] fwd, output bit nr);
    fwd = '0;
    nr  = 1'b0;
    if (!u || rs == 0) return;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      int st;
      st = cyc - hist[i].cyc;
      if (st >= 1 && st <= D && hist[i].rd == rs) begin
        if (st >= 1 + (hist[i].ld ? LL : 0) + (early ? 1 : 0)) fwd = D'(1 << (st - 1));
        else nr = 1'b1;
        return;
      end
    end
  endfunction

  task automatic evalCheck();
    bit nrA, nrB;
    @(negedge clk);
    evalOp(useA, int'(rsA), earlyA, expFwdA, nrA);
    evalOp(useB, int'(rsB), earlyB, expFwdB, nrB);
    expStall = issValid & (nrA | nrB);
    checkVal("fwd_a", 32'(fwdA), 32'(expFwdA));
    checkVal("fwd_b", 32'(fwdB), 32'(expFwdB));
    checkVal("stall", 32'(stall), 32'(expStall));
    checkVal("stall_cnt", 32'(stallCnt), 32'(mStallCnt));
    checkVal("fwd_cnt", 32'(fwdCnt), 32'(mFwdCnt));
  endtask

  function automatic logic [SW-1:0] sat(input logic [SW-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  task automatic clockUp();
    @(posedge clk);
    if (rst) begin
      hist.delete();
      mStallCnt = '0;
      mFwdCnt   = '0;
    end else begin
`ifdef HAZ_STATS_EN
      if (expStall) mStallCnt = sat(mStallCnt);
      if (issValid && !expStall && !flush && (expFwdA != 0 || expFwdB != 0)) mFwdCnt = sat(mFwdCnt);
`endif
      if (flush) hist.delete();
      else if (issValid && rdWe && rd != 0 && !expStall) hist.push_back('{cyc, int'(rd), isLoad});
    end
    cyc++;
    while (hist.size() > 0 && cyc - hist[0].cyc > D) void'(hist.pop_front());
    #1;
  endtask

  task automatic idle();
    issValid = 0; useA = 0; useB = 0; earlyA = 0; earlyB = 0;
    rdWe = 0; isLoad = 0; flush = 0; rsA = '0; rsB = '0; rd = '0;
  endtask

  task automatic produce(input int r, input bit ld);
    idle(); issValid = 1; rdWe = 1; rd = RB'(r); isLoad = ld;
  endtask

  task automatic drain();
    idle();
    repeat (D + 1) begin evalCheck(); clockUp(); end
  endtask

  initial begin
`ifdef HAZ_STATS_EN
    statOne = SW'(1);
`else
    statOne = '0;
`endif
    idle(); rst = 1;
    clockUp(); clockUp();
    rst = 0;
    evalCheck();
    checkVal("rst_stall", 32'(stall), 32'd0);
    checkVal("rst_fwd_a", 32'(fwdA), 32'd0);
    checkVal("rst_fwd_b", 32'(fwdB), 32'd0);
    checkVal("rst_stall_cnt", 32'(stallCnt), 32'd0);
    checkVal("rst_fwd_cnt", 32'(fwdCnt), 32'd0);
    clockUp();

    produce(3, 0); evalCheck(); clockUp();
    idle(); issValid = 1; useA = 1; rsA = 3;
    evalCheck(); checkVal("alu_fwd_s1", 32'(fwdA), 32'b001); checkVal("alu_nostall", 32'(stall), 32'd0); clockUp();
    evalCheck(); checkVal("alu_fwd_s2", 32'(fwdA), 32'b010); clockUp();
    drain();

    produce(5, 1); evalCheck(); clockUp();
    idle(); issValid = 1; useB = 1; rsB = 5;
    evalCheck(); checkVal("ld_use_stall", 32'(stall), 32'd1); checkVal("ld_use_fwd0", 32'(fwdB), 32'd0); clockUp();
    evalCheck(); checkVal("ld_use_fwd_s2", 32'(fwdB), 32'b010); checkVal("ld_use_go", 32'(stall), 32'd0); clockUp();
    drain();

    produce(7, 0); evalCheck(); clockUp();
    produce(7, 0); evalCheck(); clockUp();
    idle(); issValid = 1; useA = 1; rsA = 7;
    evalCheck(); checkVal("youngest_wins", 32'(fwdA), 32'b001); clockUp();
    drain();

    produce(0, 0); evalCheck(); clockUp();
    idle(); issValid = 1; useA = 1; rsA = 0;
    evalCheck(); checkVal("r0_fwd", 32'(fwdA), 32'd0); checkVal("r0_stall", 32'(stall), 32'd0); clockUp();
    produce(4, 0); evalCheck(); clockUp();
    idle(); issValid = 1; useB = 0; rsB = 4;
    evalCheck(); checkVal("nouse_fwd", 32'(fwdB), 32'd0); checkVal("nouse_stall", 32'(stall), 32'd0); clockUp();
    drain();

    produce(6, 0); evalCheck(); clockUp();
    idle(); issValid = 1; useA = 1; earlyA = 1; rsA = 6;
    evalCheck(); checkVal("early_stall", 32'(stall), 32'd1); clockUp();
    evalCheck(); checkVal("early_fwd_s2", 32'(fwdA), 32'b010); checkVal("early_go", 32'(stall), 32'd0); clockUp();
    drain();

    idle(); rst = 1; clockUp(); rst = 0;
    produce(5, 1); evalCheck(); clockUp();
    idle(); issValid = 1; useB = 1; rsB = 5;
    evalCheck(); checkVal("fl_stall", 32'(stall), 32'd1); clockUp();
    flush = 1; evalCheck(); clockUp();
    flush = 0;
    evalCheck();
    checkVal("fl_after_stall", 32'(stall), 32'd0);
    checkVal("fl_after_fwd", 32'(fwdB), 32'd0);
    checkVal("fl_stall_cnt", 32'(stallCnt), 32'(statOne));
    clockUp();
    drain();

    produce(9, 1); evalCheck(); clockUp();
    idle(); issValid = 1; useA = 1; rsA = 9;
    evalCheck(); checkVal("rst_mid_stall", 32'(stall), 32'd1);
    rst = 1; clockUp(); rst = 0;
    evalCheck(); checkVal("rst_drops_stall", 32'(stall), 32'd0); clockUp();

    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 63) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      issValid = ($urandom_range(0, 3) != 0);
      useA     = ($urandom_range(0, 3) != 0);
      useB     = ($urandom_range(0, 1) != 0);
      earlyA   = ($urandom_range(0, 3) == 0);
      earlyB   = ($urandom_range(0, 3) == 0);
      rsA      = RB'($urandom_range(0, 7));
      rsB      = RB'($urandom_range(0, 7));
      rd       = RB'($urandom_range(0, 7));
      rdWe     = ($urandom_range(0, 3) != 0);
      isLoad   = ($urandom_range(0, 2) == 0);
      evalCheck();
      clockUp();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
